// File: rtl/sbp_pipeline_arbiter_if.sv
// sbp_pipeline_arbiter_if: request channels and pipeline-head slot
// master drives requests, slave is the arbiter.
interface sbp_pipeline_arbiter_if #(
  parameter int STAGE_ID_BITS = 6,
  parameter int LOCATION_BITS = 11,
  parameter int RESULT_BITS   = 24
);
  logic                     lkp_valid_i;
  logic                     lkp_ready_o;
  logic [31:0]              lkp_ip_addr_i;
  logic                     upd_valid_i;
  logic                     upd_ready_o;
  logic [31:0]              upd_prefix_i;
  logic [5:0]               upd_prefix_len_i;
  logic [STAGE_ID_BITS-1:0] upd_stage_id_i;
  logic [LOCATION_BITS-1:0] upd_location_i;
  logic [RESULT_BITS-1:0]   upd_result_i;
  logic                     valid_o;
  logic                     update_o;
  logic [31:0]              ip_addr_o;
  logic [5:0]               bit_pos_o;
  logic [STAGE_ID_BITS-1:0] stage_id_o;
  logic [LOCATION_BITS-1:0] location_o;
  logic [RESULT_BITS-1:0]   result_o;
  logic                     busy_o;

  modport master (
    output lkp_valid_i, lkp_ip_addr_i,
    output upd_valid_i, upd_prefix_i,
    output upd_prefix_len_i, upd_stage_id_i,
    output upd_location_i, upd_result_i,
    input  lkp_ready_o, upd_ready_o,
    input  valid_o, update_o, ip_addr_o,
    input  bit_pos_o, stage_id_o,
    input  location_o, result_o, busy_o
  );

  modport slave (
    input  lkp_valid_i, lkp_ip_addr_i,
    input  upd_valid_i, upd_prefix_i,
    input  upd_prefix_len_i, upd_stage_id_i,
    input  upd_location_i, upd_result_i,
    output lkp_ready_o, upd_ready_o,
    output valid_o, update_o, ip_addr_o,
    output bit_pos_o, stage_id_o,
    output location_o, result_o, busy_o
  );
endinterface

// File: rtl/sbp_pipeline_arbiter.sv
// sbp_pipeline_arbiter: lookup/update arbiter at the pipeline head.
// SBP_ARB_DRAIN_EN enables the DRAIN state ahead of update bursts.
module sbp_pipeline_arbiter #(
  parameter int STAGE_ID_BITS = 6,
  parameter int LOCATION_BITS = 11,
  parameter int RESULT_BITS   = 24,
  parameter int PIPE_STAGES   = 32,
  parameter int MAX_UPD_BURST = 8
) (
  input logic clk,
  input logic rst,
  sbp_pipeline_arbiter_if.slave bus
);

  localparam int BW = $clog2(MAX_UPD_BURST + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
`ifdef SBP_ARB_DRAIN_EN
    DRAIN  = 2'd1,
`endif
    UPDATE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          bexit_q, bexit_d;
  logic          lkp_rdy, upd_rdy;
  logic          lkp_fire, upd_fire;

`ifdef SBP_ARB_DRAIN_EN
  localparam int DW = $clog2(PIPE_STAGES + 1);
  logic [DW-1:0] drain_q, drain_d;
`endif

  logic                     v_q, u_q;
  logic [31:0]              addr_q;
  logic [5:0]               bpos_q;
  logic [STAGE_ID_BITS-1:0] stage_q;
  logic [LOCATION_BITS-1:0] loc_q;
  logic [RESULT_BITS-1:0]   res_q;

  assign lkp_fire = bus.lkp_valid_i & lkp_rdy;
  assign upd_fire = bus.upd_valid_i & upd_rdy;

  // next-state, counters and channel readiness
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    bexit_d = bexit_q;
    lkp_rdy = 1'b0;
    upd_rdy = 1'b0;
`ifdef SBP_ARB_DRAIN_EN
    drain_d = drain_q;
`endif
    unique case (state_q)
      RUN: begin
        if (bexit_q) begin
          lkp_rdy = 1'b1;
          bexit_d = 1'b0;
        end else begin
          lkp_rdy = ~bus.upd_valid_i;
          if (bus.upd_valid_i) begin
`ifdef SBP_ARB_DRAIN_EN
            state_d = DRAIN;
            drain_d = DW'(PIPE_STAGES);
`else
            state_d = UPDATE;
            burst_d = '0;
`endif
          end
        end
      end
`ifdef SBP_ARB_DRAIN_EN
      DRAIN: begin
        drain_d = drain_q - 1'b1;
        if (drain_q == DW'(1)) begin
          state_d = UPDATE;
          burst_d = '0;
        end
      end
`endif
      UPDATE: begin
        upd_rdy = 1'b1;
        if (!bus.upd_valid_i) begin
          state_d = RUN;
        end else begin
          burst_d = burst_q + 1'b1;
          if (burst_d == BW'(MAX_UPD_BURST)) begin
            state_d = RUN;
            bexit_d = 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  // state and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      burst_q <= '0;
      bexit_q <= 1'b0;
`ifdef SBP_ARB_DRAIN_EN
      drain_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      bexit_q <= bexit_d;
`ifdef SBP_ARB_DRAIN_EN
      drain_q <= drain_d;
`endif
    end
  end

  // pipeline-head slot: lookup, update or empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q     <= 1'b0;
      u_q     <= 1'b0;
      addr_q  <= '0;
      bpos_q  <= '0;
      stage_q <= '0;
      loc_q   <= '0;
      res_q   <= '0;
    end else if (lkp_fire) begin
      v_q     <= 1'b1;
      u_q     <= 1'b0;
      addr_q  <= bus.lkp_ip_addr_i;
      bpos_q  <= '0;
      stage_q <= STAGE_ID_BITS'(1);
      loc_q   <= '0;
      res_q   <= '0;
    end else if (upd_fire) begin
      v_q     <= 1'b1;
      u_q     <= 1'b1;
      addr_q  <= bus.upd_prefix_i;
      bpos_q  <= bus.upd_prefix_len_i;
      stage_q <= bus.upd_stage_id_i;
      loc_q   <= bus.upd_location_i;
      res_q   <= bus.upd_result_i;
    end else begin
      v_q     <= 1'b0;
      u_q     <= 1'b0;
      addr_q  <= '0;
      bpos_q  <= '0;
      stage_q <= '0;
      loc_q   <= '0;
      res_q   <= '0;
    end
  end

  assign bus.lkp_ready_o = lkp_rdy;
  assign bus.upd_ready_o = upd_rdy;
  assign bus.busy_o      = (state_q != RUN);
  assign bus.valid_o     = v_q;
  assign bus.update_o    = u_q;
  assign bus.ip_addr_o   = addr_q;
  assign bus.bit_pos_o   = bpos_q;
  assign bus.stage_id_o  = stage_q;
  assign bus.location_o  = loc_q;
  assign bus.result_o    = res_q;

endmodule
